// File: rtl/rs232_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// rs232_pkg
// Constants shared by the RS-232 packet transmit and receive blocks: the FSM
// state encoding, the default bit period for 50 MHz / 9600 baud, and the
// header byte that opens every 8-byte packet.
// ---------------------------------------------------------------------------
package rs232_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 5208;

    localparam logic [7:0] HEADER_BYTE = 8'h02;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

endpackage

// File: rtl/baud_tick.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// baud_tick
// Bit-period timer. While en is high, tick is high for one cycle out of every
// CLKS_PER_BIT cycles (on the last cycle of each bit period). Dropping en
// clears the counter so the next period starts from zero.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   en   : run the timer
//   tick : last cycle of the current bit period
// ---------------------------------------------------------------------------
import rs232_pkg::*;

module baud_tick #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/tx_packet.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tx_packet
// Sends one 8-byte packet over an 8N1 RS-232 line, byte 0 first, LSB first,
// with GAP_BITS idle bit-times between bytes.
//   clk      : system clock
//   rst      : synchronous active-high reset (aborts a packet, line goes high)
//   tx_start : one-cycle send request, accepted only while busy is low
//   data_in  : payload, byte n in data_in[8n+7:8n]
//   tx       : registered serial line, idle high
//   busy     : packet in flight
//   done     : one-cycle pulse in the final cycle of the last stop bit
// ---------------------------------------------------------------------------
import rs232_pkg::*;

module tx_packet #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int GAP_BITS     = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [63:0] data_in,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);

    logic [2:0]       state_q, state_d;
    logic [2:0]       bit_q, bit_d;
    logic [2:0]       byte_q, byte_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [63:0]      shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             tick;
    logic             last_stop_end;
    logic             accept;

    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != ST_IDLE),
        .tick (tick)
    );

    // done and busy are decoded combinationally so that the final cycle of
    // the last stop bit is already "not busy": a tx_start seen in that cycle
    // starts the next packet on the very edge where this one ends.
    assign last_stop_end = (state_q == ST_STOP) && (byte_q == 3'd7) && tick;
    assign done          = last_stop_end && !rst;
    assign busy          = (state_q != ST_IDLE) && !last_stop_end;
    assign accept        = tx_start && !busy;
    assign tx            = tx_q;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        gap_d   = gap_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
            end
            ST_START: begin
                if (tick) begin
                    tx_d    = shreg_q[0];
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    // The shift register always presents the next bit at [0];
                    // eight shifts per byte leave the next byte in place.
                    shreg_d = {1'b0, shreg_q[63:1]};
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        tx_d  = shreg_q[1];
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (byte_q == 3'd7) begin
                        byte_d  = 3'd0;
                        state_d = ST_IDLE;
                    end else if (GAP_BITS > 0) begin
                        byte_d  = byte_q + 3'd1;
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (gap_q == GAP_LAST) begin
                        gap_d   = '0;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            shreg_d = data_in;
            bit_d   = 3'd0;
            byte_d  = 3'd0;
            gap_d   = '0;
            tx_d    = 1'b0;
            state_d = ST_START;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bit_q   <= 3'd0;
            byte_q  <= 3'd0;
            gap_q   <= '0;
            shreg_q <= 64'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            gap_q   <= gap_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_tx_packet.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_tx_packet
// Bench for tx_packet with a 16-cycle bit period: one instance without an
// inter-byte gap and one with a two-bit gap. Expected line levels come from
// the 8N1 framing rule; a sampling receiver reassembles the captured line.
// ---------------------------------------------------------------------------
import rs232_pkg::*;

module tb_tx_packet;

    localparam int C = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start2;
    logic [63:0] data0, data2;
    logic        tx0, busy0, done0;
    logic        tx2, busy2, done2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tx_packet #(.CLKS_PER_BIT(C), .GAP_BITS(0)) dut0 (
        .clk(clk), .rst(rst), .tx_start(start0), .data_in(data0),
        .tx(tx0), .busy(busy0), .done(done0)
    );

    tx_packet #(.CLKS_PER_BIT(C), .GAP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .tx_start(start2), .data_in(data2),
        .tx(tx2), .busy(busy2), .done(done2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level during bit-time b of a packet: each byte is a 0 start bit,
    // eight data bits LSB first, a 1 stop bit, then g idle 1 bits.
    function automatic logic exp_level(input logic [63:0] d, input int g, input int b);
        int slot = 10 + g;
        int byt  = b / slot;
        int pos  = b % slot;
        if (byt > 7)  return 1'b1;
        if (pos == 0) return 1'b0;
        if (pos <= 8) return d[8*byt + pos - 1];
        return 1'b1;
    endfunction

    function automatic logic [2:0] obs_of(input int g);
        return (g == 0) ? {tx0, busy0, done0} : {tx2, busy2, done2};
    endfunction

    task automatic set_start(input int g, input logic s, input logic [63:0] d);
        if (g == 0) begin
            start0 = s;
            data0  = d;
        end else begin
            start2 = s;
            data2  = d;
        end
    endtask

    function automatic logic [63:0] rand_packet();
        logic [63:0] r;
        r = {$urandom, $urandom};
        r[7:0] = HEADER_BYTE;
        return r;
    endfunction

    // Called one time unit after the accepting edge. Checks every cycle of
    // the packet, scrambles data_in after acceptance, optionally raises a
    // request mid-packet, and optionally requests the next packet in the
    // done cycle.
    task automatic run_packet(input string tag, input int g, input logic [63:0] d,
                              input int req_at, input bit chain, input logic [63:0] chain_d);
        int          n         = (80 + 7*g) * C;
        int          wave_err  = 0;
        int          busy_err  = 0;
        int          done_cnt  = 0;
        int          done_at   = -1;
        int          first_bad = -1;
        int          frame_err = 0;
        logic        cap [0:2047];
        logic [63:0] rx;
        logic [2:0]  o;
        for (int i = 0; i < n; i++) begin
            o = obs_of(g);
            if (o[2] !== exp_level(d, g, i / C)) begin
                wave_err++;
                if (first_bad < 0) first_bad = i;
            end
            if (o[1] !== (i != n - 1)) busy_err++;
            if (o[0] === 1'b1) begin
                done_cnt++;
                done_at = i;
            end
            cap[i] = o[2];
            if (i == 0)           set_start(g, 1'b0, {$urandom, $urandom});
            if (i == req_at)      set_start(g, 1'b1, {$urandom, $urandom});
            if (i == req_at + 1)  set_start(g, 1'b0, {$urandom, $urandom});
            if (chain && i == n - 1) set_start(g, 1'b1, chain_d);
            @(posedge clk); #1;
        end
        check({tag, "_wave_errs"}, 64'(wave_err), 64'd0);
        check({tag, "_first_bad"}, 64'(first_bad), 64'hFFFF_FFFF_FFFF_FFFF);
        check({tag, "_busy_errs"}, 64'(busy_err), 64'd0);
        check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        check({tag, "_done_cycle"}, 64'(done_at), 64'(n - 1));
        rx = '0;
        for (int by = 0; by < 8; by++) begin
            int base = by * (10 + g) * C;
            if (cap[base + C/2] !== 1'b0) frame_err++;
            if (cap[base + 9*C + C/2] !== 1'b1) frame_err++;
            for (int k = 0; k < 8; k++) rx[8*by + k] = cap[base + (1 + k)*C + C/2];
        end
        check({tag, "_rx_frame_errs"}, 64'(frame_err), 64'd0);
        check({tag, "_rx_data"}, rx, d);
        if (!chain) begin
            check({tag, "_after_idle"}, 64'(obs_of(g)), 64'b100);
        end
    endtask

    initial begin
        logic [63:0] d;
        int          dseen;

        rst = 1'b1;
        set_start(0, 1'b0, 64'd0);
        set_start(2, 1'b0, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx0",   64'(tx0),   64'd1);
        check("reset_busy0", 64'(busy0), 64'd0);
        check("reset_done0", 64'(done0), 64'd0);
        check("reset_tx2",   64'(tx2),   64'd1);
        check("reset_busy2", 64'(busy2), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", 64'(obs_of(0)), 64'b100);

        // Basic packet with the documented payload
        d = 64'h0123_4567_89AB_CD02;
        set_start(0, 1'b1, d);
        @(posedge clk); #1;
        run_packet("basic", 0, d, -1, 1'b0, 64'd0);

        // A request during busy must be ignored
        d = 64'h0123_4567_89AB_CD02;
        set_start(0, 1'b1, d);
        @(posedge clk); #1;
        run_packet("req_busy", 0, d, 100, 1'b0, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("req_busy_no_restart", 64'(obs_of(0)), 64'b100);

        // Back-to-back: next request in the done cycle
        d = rand_packet();
        set_start(0, 1'b1, d);
        @(posedge clk); #1;
        run_packet("b2b_first", 0, d, -1, 1'b1, 64'hFFFF_FFFF_FFFF_FF02);
        run_packet("b2b_second", 0, 64'hFFFF_FFFF_FFFF_FF02, -1, 1'b0, 64'd0);

        // Reset in the middle of a byte
        d = rand_packet();
        set_start(0, 1'b1, d);
        @(posedge clk); #1;
        set_start(0, 1'b0, 64'd0);
        dseen = 0;
        for (int i = 0; i < 500; i++) begin
            if (done0 === 1'b1) dseen++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_tx",   64'(tx0),   64'd1);
        check("midrst_busy", 64'(busy0), 64'd0);
        check("midrst_done", 64'(done0), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 4 * C; i++) begin
            if (done0 === 1'b1 || tx0 !== 1'b1 || busy0 !== 1'b0) dseen++;
            @(posedge clk); #1;
        end
        check("midrst_quiet", 64'(dseen), 64'd0);
        d = rand_packet();
        set_start(0, 1'b1, d);
        @(posedge clk); #1;
        run_packet("after_rst", 0, d, -1, 1'b0, 64'd0);

        // Inter-byte gap of two bit-times, zero payload
        set_start(2, 1'b1, 64'd0);
        @(posedge clk); #1;
        run_packet("gap_zero", 2, 64'd0, -1, 1'b0, 64'd0);

        // Loopback-style payload and randomized packets
        d = 64'h1122_3344_5566_7702;
        set_start(0, 1'b1, d);
        @(posedge clk); #1;
        run_packet("loopback", 0, d, -1, 1'b0, 64'd0);
        for (int r = 0; r < 3; r++) begin
            d = rand_packet();
            set_start(0, 1'b1, d);
            @(posedge clk); #1;
            run_packet("rand0", 0, d, -1, 1'b0, 64'd0);
        end
        d = rand_packet();
        set_start(2, 1'b1, d);
        @(posedge clk); #1;
        run_packet("rand_gap", 2, d, -1, 1'b0, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
